hex_keypad_entry: RTL

Scans a 4x4 hex keypad (Pmod KYPD style: active-low column drives, active-low pulled-up row inputs) and debounces presses. Each accepted key is shifted into a 16-bit entry register, one hex digit per press. It is the input-side counterpart of the board's multiplexed 4-digit hex display, and its `value` output is sized to drive that display and the processor's input port directly.

---
 rtl/hex_keypad_pkg.sv | 81 ++++++++
 rtl/hex_keypad_entry_debounce.sv | 129 ++++++++++++
 rtl/hex_keypad_entry.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hex_keypad_pkg.sv
// hex_keypad_pkg
//   Shared types and helpers for the hex keypad entry block.
//   - KEY_MAP: 4x4 key map packed one nibble per key, indexed by {row, col}.
//   - kp_state_e: press-tracking FSM states (IDLE, HELD).
//   - scan_res_t: result of one column slot or one full scan
//     (NONE, SINGLE with a 4-bit key code, MULTI).
//   - key_lookup / slot_result / merge_result: pure helpers used by the
//     scanner to build a full-scan result slot by slot.
package hex_keypad_pkg;

    // Nibble n holds the key printed at row n[3:2], column n[1:0].
    // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } kp_state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_kind_e;

    // code is only meaningful for RES_SINGLE and is kept at zero otherwise,
    // so two results can be compared as whole words.
    typedef struct packed {
        res_kind_e  kind;
        logic [3:0] code;
    } scan_res_t;

    localparam scan_res_t SCAN_NONE  = '{kind: RES_NONE,  code: 4'h0};
    localparam scan_res_t SCAN_MULTI = '{kind: RES_MULTI, code: 4'h0};

    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        logic [5:0] base;
        base = {row_idx, col_idx, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

    // Classify the (active-high) row-low vector seen while one column is driven.
    function automatic scan_res_t slot_result(input logic [3:0] rows_low,
                                              input logic [1:0] col_idx);
        scan_res_t  res;
        logic [1:0] row_idx;
        row_idx = 2'd0;
        res     = SCAN_MULTI;
        case (rows_low)
            4'b0000: res = SCAN_NONE;
            4'b0001: row_idx = 2'd0;
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: res = SCAN_MULTI;
        endcase
        if ((rows_low == 4'b0001) || (rows_low == 4'b0010) ||
            (rows_low == 4'b0100) || (rows_low == 4'b1000)) begin
            res.kind = RES_SINGLE;
            res.code = key_lookup(row_idx, col_idx);
        end else begin
            res = res;
        end
        return res;
    endfunction

    // Fold one slot into the result accumulated so far in this scan.
    // A second key anywhere in the scan turns the result into MULTI.
    function automatic scan_res_t merge_result(input scan_res_t acc,
                                               input scan_res_t slot);
        scan_res_t res;
        case (slot.kind)
            RES_NONE:   res = acc;
            RES_SINGLE: res = (acc.kind == RES_NONE) ? slot : SCAN_MULTI;
            default:    res = SCAN_MULTI;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hex_keypad_entry_debounce.sv
// keypad_debounce
//   Debounces full-scan results and tracks press/release of one key.
//   A result must repeat on DEBOUNCE_SCANS consecutive scans to count;
//   MULTI never counts and restarts the run. While HELD, other keys are
//   ignored until the keypad is debounced as fully released (no rollover).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   scan_done     one-cycle pulse, scan_result valid for a completed scan
//   scan_result   result of the completed scan
//   accept        combinational pulse on the scan_done cycle that accepts
//                 a press (top level registers it into key_strobe)
//   key_code      registered code of the last accepted key
//   key_held      high while in HELD
module keypad_debounce
    import hex_keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_done,
    input  scan_res_t  scan_result,
    output logic       accept,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int               CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

    kp_state_e        state_r;
    kp_state_e        state_next_s;
    logic [CNT_W-1:0] stable_cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    scan_res_t        last_result_r;
    logic             qualified_s;
    logic             accept_s;
    logic [3:0]       key_code_r;

    // Run length of the incoming result; saturates once it qualifies.
    always_comb begin
        cnt_next_s = stable_cnt_r;
        if (scan_result.kind == RES_MULTI) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (scan_result == last_result_r) begin
            if (stable_cnt_r < CNT_TARGET) begin
                cnt_next_s = stable_cnt_r + CNT_W'(1);
            end else begin
                cnt_next_s = stable_cnt_r;
            end
        end else begin
            cnt_next_s = CNT_W'(1);
        end
    end

    assign qualified_s = scan_done && (scan_result.kind != RES_MULTI) &&
                         (cnt_next_s >= CNT_TARGET);

    // Stable-count and previous-result registers, advanced once per scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt_r  <= {CNT_W{1'b0}};
            last_result_r <= SCAN_NONE;
        end else if (scan_done) begin
            stable_cnt_r  <= cnt_next_s;
            last_result_r <= scan_result;
        end else begin
            stable_cnt_r  <= stable_cnt_r;
            last_result_r <= last_result_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (qualified_s && (scan_result.kind == RES_SINGLE)) begin
                    state_next_s = ST_HELD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (qualified_s && (scan_result.kind == RES_NONE)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HELD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: a press is accepted on the IDLE -> HELD transition.
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: accept_s = (state_next_s == ST_HELD);
            ST_HELD: accept_s = 1'b0;
            default: accept_s = 1'b0;
        endcase
    end

    // Latch the code of the accepted key.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code_r <= 4'h0;
        end else if (accept_s) begin
            key_code_r <= scan_result.code;
        end else begin
            key_code_r <= key_code_r;
        end
    end

    assign accept   = accept_s;
    assign key_code = key_code_r;
    assign key_held = (state_r == ST_HELD);

endmodule

// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry
//   Scans a 4x4 active-low hex keypad, debounces presses and shifts each
//   accepted key into a 16-bit entry register (newest digit in [3:0]).
//   Optional macro KEYPAD_SYNC_EN: when defined, row passes through a 2-flop
//   synchronizer before sampling; when undefined, row is sampled directly.
// Parameters:
//   SCAN_CYCLES     cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive identical scans to accept press/release (>= 1)
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   row[3:0]    keypad rows, active-low, row[0] top
//   clr         level, clears value on the next edge (wins over a press)
//   col[3:0]    one-cold column drive, col[0] leftmost
//   key_code    code of the last accepted key
//   key_strobe  one-cycle pulse per accepted press
//   key_held    high while the accepted key is not yet released
//   value       entry register
module hex_keypad_entry
    import hex_keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 100_000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic        key_held,
    output logic [15:0] value
);

    localparam int              TMR_W    = $clog2(SCAN_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCAN_CYCLES - 1);

    logic [TMR_W-1:0] scan_timer_r;
    logic [1:0]       col_idx_r;
    logic [3:0]       col_r;
    logic [3:0]       row_s;
    logic             sample_en_s;
    logic             scan_done_s;
    scan_res_t        slot_res_s;
    scan_res_t        merged_s;
    scan_res_t        acc_r;
    logic             accept_s;
    logic [3:0]       db_key_code_s;
    logic             db_key_held_s;
    logic             key_strobe_r;
    logic [15:0]      value_r;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] row_meta_r;
    logic [3:0] row_sync_r;

    // Two-flop synchronizer for the asynchronous keypad rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= row;
            row_sync_r <= row_meta_r;
        end
    end

    assign row_s = row_sync_r;
`else
    assign row_s = row;
`endif

    // Column timer and one-cold column drive; the column steps on the edge
    // where the timer wraps, so the new column appears the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_timer_r <= {TMR_W{1'b0}};
            col_idx_r    <= 2'd0;
            col_r        <= 4'b1110;
        end else if (scan_timer_r == TMR_LAST) begin
            scan_timer_r <= {TMR_W{1'b0}};
            col_idx_r    <= col_idx_r + 2'd1;
            col_r        <= {col_r[2:0], col_r[3]};
        end else begin
            scan_timer_r <= scan_timer_r + TMR_W'(1);
            col_idx_r    <= col_idx_r;
            col_r        <= col_r;
        end
    end

    // Rows are sampled on the last cycle of each column slot for maximum settle.
    assign sample_en_s = (scan_timer_r == TMR_LAST);
    assign scan_done_s = sample_en_s && (col_idx_r == 2'd3);
    assign slot_res_s  = slot_result(~row_s, col_idx_r);
    assign merged_s    = merge_result(acc_r, slot_res_s);

    // Per-scan accumulator; merged_s on the col3 sample is the full-scan result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= SCAN_NONE;
        end else if (scan_done_s) begin
            acc_r <= SCAN_NONE;
        end else if (sample_en_s) begin
            acc_r <= merged_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .scan_done   (scan_done_s),
        .scan_result (merged_s),
        .accept      (accept_s),
        .key_code    (db_key_code_s),
        .key_held    (db_key_held_s)
    );

    // Strobe and entry shifter; clr has priority over a coincident press.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_strobe_r <= 1'b0;
            value_r      <= 16'h0000;
        end else begin
            key_strobe_r <= accept_s;
            if (clr) begin
                value_r <= 16'h0000;
            end else if (accept_s) begin
                value_r <= {value_r[11:0], merged_s.code};
            end else begin
                value_r <= value_r;
            end
        end
    end

    assign col        = col_r;
    assign key_code   = db_key_code_s;
    assign key_held   = db_key_held_s;
    assign key_strobe = key_strobe_r;
    assign value      = value_r;

endmodule
